// File: rtl/multi_timer_pkg.sv
// timer_pkg: shared types for the multi-channel timer.
//   mode_e  : per-channel count mode (one-shot / periodic auto-reload)
//   state_e : per-channel run state
package timer_pkg;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/multi_timer_if.sv
// multi_timer_if: control/status bundle of the multi-channel timer.
//   master : register block side (drives load/mode/enable/prescale/irq_clr)
//   slave  : timer side (drives time_out/irq_status/irq/running/count)
interface multi_timer_if #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned PRESCALE_W = 8
);
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH*WIDTH-1:0] load_val;
  logic [NUM_CH-1:0]       mode;
  logic [NUM_CH-1:0]       enable;
  logic [PRESCALE_W-1:0]   prescale;
  logic [NUM_CH-1:0]       irq_clr;
  logic [NUM_CH-1:0]       time_out;
  logic [NUM_CH-1:0]       irq_status;
  logic                    irq;
  logic [NUM_CH-1:0]       running;
  logic [NUM_CH*WIDTH-1:0] count;

  modport master (
    output load, load_val, mode, enable, prescale, irq_clr,
    input  time_out, irq_status, irq, running, count
  );

  modport slave (
    input  load, load_val, mode, enable, prescale, irq_clr,
    output time_out, irq_status, irq, running, count
  );
endinterface

// File: rtl/multi_timer_channel.sv
// timer_channel: one down-counting timer channel.
//   clk, rst   : clock, asynchronous active-high reset
//   tick       : shared prescaler tick
//   load       : load strobe, load_val value (0 parks the channel idle)
//   mode       : 0 one-shot, 1 periodic auto-reload
//   enable     : run enable, low freezes the count
//   irq_clr    : clear strobe for the sticky status
//   time_out   : one-cycle expiry pulse
//   irq_status : sticky expiry flag
//   running    : channel in ST_RUN
//   count      : current counter value
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  input  logic             enable,
  input  logic             irq_clr,
  output logic             time_out,
  output logic             irq_status,
  output logic             running,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_e           state;
  logic [WIDTH-1:0] reload;
  logic             step;
  logic             expire;

  // Expiry is detected at 1 so the count never wraps below zero.
  // A load on the same edge takes priority and suppresses the expiry.
  assign step    = (state == ST_RUN) && tick && enable;
  assign expire  = step && (count == CNT_ONE) && !load;
  assign running = (state == ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      count      <= '0;
      reload     <= '0;
      time_out   <= 1'b0;
      irq_status <= 1'b0;
    end else begin
      time_out <= 1'b0;
      if (load) begin
        count  <= load_val;
        reload <= load_val;
        state  <= (load_val != '0) ? ST_RUN : ST_IDLE;
      end else if (step) begin
        if (count == CNT_ONE) begin
          time_out <= 1'b1;
          if (mode_e'(mode) == MODE_PERIODIC) begin
            count <= reload;
          end else begin
            count <= '0;
            state <= ST_IDLE;
          end
        end else begin
          count <= count - CNT_ONE;
        end
      end

      // Set wins over a simultaneous clear.
      if (expire) begin
        irq_status <= 1'b1;
      end else if (irq_clr) begin
        irq_status <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_timer.sv
// multi_timer: NUM_CH independent down-counting timers sharing one prescaler.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : multi_timer_if slave port
//              inputs  load, load_val, mode, enable, prescale, irq_clr
//              outputs time_out, irq_status, irq (OR of status), running, count
module multi_timer
  import timer_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  multi_timer_if.slave   bus
);

  logic [PRESCALE_W-1:0] pc;
  logic                  tick;

  // >= rather than == so lowering prescale below pc still wraps at once.
  assign tick = (pc >= bus.prescale);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else if (tick) begin
      pc <= '0;
    end else begin
      pc <= pc + PRESCALE_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .load       (bus.load[i]),
      .load_val   (bus.load_val[i*WIDTH +: WIDTH]),
      .mode       (bus.mode[i]),
      .enable     (bus.enable[i]),
      .irq_clr    (bus.irq_clr[i]),
      .time_out   (bus.time_out[i]),
      .irq_status (bus.irq_status[i]),
      .running    (bus.running[i]),
      .count      (bus.count[i*WIDTH +: WIDTH])
    );
  end

  assign bus.irq = |bus.irq_status;

endmodule

// File: doc/multi_timer.md
# multi_timer

Parametrised multi-channel down-counting timer with a shared prescaler, per-channel one-shot or periodic (auto-reload) mode, run/pause control and sticky interrupt status. It generalises the single 8-bit periodic timer to NUM_CH independent channels of WIDTH bits. It sits on the peripheral side of the design, with control driven by a register block, and drives a single aggregated interrupt line.

## Interface
- NUM_CH, default 4: number of independent channels (1..16).
- WIDTH, default 16: counter and load width per channel.
- PRESCALE_W, default 8: width of the shared prescaler divisor.

- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  NUM_CH  per-channel load strobe.
- load_val  in  NUM_CH*WIDTH  packed load values; channel i is bits [i*WIDTH +: WIDTH].
- mode  in  NUM_CH  per-channel mode: 0 = one-shot, 1 = periodic.
- enable  in  NUM_CH  per-channel run enable; low pauses the count.
- prescale  in  PRESCALE_W  tick divisor P; one tick every P+1 clk cycles.
- irq_clr  in  NUM_CH  per-channel status clear strobe.
- time_out  out  NUM_CH  one-cycle expiry pulse per channel.
- irq_status  out  NUM_CH  sticky expiry flags.
- irq  out  1  OR of irq_status.
- running  out  NUM_CH  channel is in ST_RUN.
- count  out  NUM_CH*WIDTH  current counter values, packed as load_val.

## Operation
- **Reset values.** On rst, all registers clear: prescaler count = 0, every channel in ST_IDLE, count = 0, reload = 0, time_out = 0, irq_status = 0. Consequently irq = 0 and running = 0.
- **Prescaler.** The free-running counter pc compares against prescale.
  - If pc >= prescale: tick = 1 and pc <= 0.
  - Otherwise: pc <= pc + 1.
  - P = 0 gives a tick every cycle.
  - A change to prescale takes effect immediately. The >= compare guarantees a wrap when prescale is lowered below pc.
- **Channel states.** Each channel has two states, ST_IDLE and ST_RUN. Priority per cycle: load > expiry/decrement > hold.
  - **load in any state:**
    - count <= load_val and reload <= load_val.
    - Go to ST_RUN if load_val != 0; otherwise go to ST_IDLE with count = 0.
    - No decrement occurs in the load cycle, even if tick = 1.
  - **ST_RUN, tick and enable, count == 1 (expiry):**
    - time_out <= 1.
    - Periodic: count <= reload and stay in ST_RUN.
    - One-shot: count <= 0 and go to ST_IDLE.
  - **ST_RUN, tick and enable, count > 1:** count <= count - 1.
  - **ST_RUN, enable low or no tick:** hold.
  - **ST_IDLE:** hold. Ticks are ignored.
- **time_out.** Registered, and high for exactly one cycle per expiry. In all other cycles time_out <= 0.
- **irq_status[i].**
  - Set in the cycle time_out[i] rises, i.e. on the same edge as the expiry.
  - Cleared by irq_clr[i].
  - Set wins over a simultaneous clear.
- **irq.** Combinational OR of irq_status.
- **Arithmetic.** Unsigned, WIDTH bits. Count never wraps below 0, because expiry is detected at 1. A reload of 2^WIDTH-1 is legal.

## Timing
- Period of a periodic channel with enable held high: load_val*(P+1) clk cycles between successive time_out pulses.
- Latency from load to the first time_out: from (load_val-1)*(P+1)+1 to load_val*(P+1) cycles. The prescaler phase is shared and is not reset by load.
- With P = 0, a load of N on edge k produces time_out high in the cycle after edge k+N.
- Deasserting enable freezes count and defers expiry by exactly the number of ticks missed.
- A load in the same cycle as an expiry suppresses that expiry: no time_out and no status set.
- Reset mid-operation returns every output to its reset value within the same cycle; it is asynchronous.
- Channels are fully independent. Multiple channels may expire in the same cycle.

## Structure
- Package timer_pkg holds:
  - mode_e: MODE_ONESHOT = 1'b0, MODE_PERIODIC = 1'b1.
  - state_e: ST_IDLE, ST_RUN.
- Sub-module timer_channel holds count, reload, state, time_out and irq_status for one channel, parametrised by WIDTH.
- The top level holds the prescaler and a generate loop of NUM_CH timer_channel instances, and produces the irq OR.

## Test plan
- **Periodic, P = 0.** Channel 0, mode = 1, load_val = 5, enable = 1. Required: time_out[0] pulses every 5 cycles for at least 4 periods; irq_status[0] = 1; irq = 1.
- **One-shot.** Channel 1, mode = 0, load_val = 3, P = 0. Required: a single time_out[1] 3 cycles after load; then running[1] = 0, count = 0, and no further pulses.
- **Prescaler.** P = 3, periodic, load_val = 2. Required: pulse spacing of 8 cycles; count steps only on ticks.
- **Pause.** Periodic, load_val = 4, P = 0; enable dropped for 6 cycles mid-count. Required: expiry delayed by exactly 6 cycles; count held throughout the pause.
- **Simultaneous events.**
  - irq_clr[0] coincident with an expiry: irq_status[0] stays 1.
  - Load coincident with an expiry: no time_out; count = new load_val.
- **Reset and zero load.**
  - rst asserted mid-count: all outputs are 0 immediately.
  - load_val = 0: channel stays in ST_IDLE and never times out.
